demux1_3_reg: RTL

//  - Registered 1:3 demultiplexer with valid/ready handshake; the dispatch-side counterpart of Mux3_1.
//  - Routes one 32-bit word per accepted transfer to output channel A, B or C, selected by {controle1,controle2}.
//  - Sits between a single producer (ALU/writeback bus) and three independent consumers.
//  - Each channel holds one word, so a stalled consumer blocks only its own channel.

---
 rtl/demux_pkg.sv | 25 ++
 rtl/demux_slot.sv | 72 +++++++
 rtl/demux1_3_reg.sv | 105 ++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared select encodings, default widths and select decode for the registered 1:3 demultiplexer.
package demux_pkg;

    localparam int LARGURA_DEF = 32;
    localparam int CONT_W_DEF  = 16;

    localparam logic [1:0] SEL_A      = 2'b00;
    localparam logic [1:0] SEL_B      = 2'b01;
    localparam logic [1:0] SEL_C      = 2'b10;
    localparam logic [1:0] SEL_ILEGAL = 2'b11;

    // One-hot {C,B,A}; the illegal code selects no channel.
    function automatic logic [2:0] decodifica(input logic [1:0] sel);
        logic [2:0] oh;
        oh = 3'b000;
        case (sel)
            SEL_A:   oh = 3'b001;
            SEL_B:   oh = 3'b010;
            SEL_C:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel with valid/ready handshake.
// Optional delivery counter present when DEMUX_CONT_EN is defined.
module demux_slot
    import demux_pkg::*;
#(
    parameter int LARGURA = LARGURA_DEF
`ifdef DEMUX_CONT_EN
    ,
    parameter int CONT_W = CONT_W_DEF
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carga,
    input  logic [LARGURA-1:0] dado_in,
    input  logic               pronta,
    output logic               valida,
    output logic [LARGURA-1:0] dado_out,
    output logic               livre
`ifdef DEMUX_CONT_EN
    ,
    output logic [CONT_W-1:0]  cont
`endif
);

    logic               valida_q, valida_d;
    logic [LARGURA-1:0] dado_q, dado_d;
    logic               entrega;

    assign entrega  = valida_q & pronta;
    assign livre    = !valida_q | pronta;
    assign valida   = valida_q;
    assign dado_out = dado_q;

    // A reload in the same cycle as a delivery keeps the slot full.
    always_comb begin
        valida_d = valida_q;
        dado_d   = dado_q;
        if (carga) begin
            valida_d = 1'b1;
            dado_d   = dado_in;
        end else if (entrega) begin
            valida_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valida_q <= 1'b0;
            dado_q   <= '0;
        end else begin
            valida_q <= valida_d;
            dado_q   <= dado_d;
        end
    end

`ifdef DEMUX_CONT_EN
    logic [CONT_W-1:0] cont_q, cont_d;

    assign cont   = cont_q;
    assign cont_d = entrega ? cont_q + CONT_W'(1) : cont_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end
`endif

endmodule

// File: rtl/demux1_3_reg.sv
// Registered 1:3 demultiplexer: routes each accepted word to channel A, B or C by {controle1,controle2}.
// Define DEMUX_CONT_EN to add per-channel delivered-word counters (contA/B/C).
module demux1_3_reg
    import demux_pkg::*;
#(
    parameter int LARGURA = LARGURA_DEF
`ifdef DEMUX_CONT_EN
    ,
    parameter int CONT_W = CONT_W_DEF
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] entrada,
    input  logic               controle1,
    input  logic               controle2,
    input  logic               entrada_valida,
    output logic               entrada_pronta,
    output logic [LARGURA-1:0] saidaA,
    output logic [LARGURA-1:0] saidaB,
    output logic [LARGURA-1:0] saidaC,
    output logic               saidaA_valida,
    output logic               saidaB_valida,
    output logic               saidaC_valida,
    input  logic               saidaA_pronta,
    input  logic               saidaB_pronta,
    input  logic               saidaC_pronta,
    output logic               erro
`ifdef DEMUX_CONT_EN
    ,
    output logic [CONT_W-1:0]  contA,
    output logic [CONT_W-1:0]  contB,
    output logic [CONT_W-1:0]  contC
`endif
);

    logic [1:0] sel;
    logic [2:0] sel_oh;
    logic [2:0] livre;
    logic [2:0] carga;
    logic       aceita;
    logic       erro_q, erro_d;

    assign sel    = {controle1, controle2};
    assign sel_oh = decodifica(sel);

    // Illegal selects are always accepted so the producer never deadlocks on them.
    always_comb begin
        entrada_pronta = 1'b1;
        case (sel)
            SEL_A:   entrada_pronta = livre[0];
            SEL_B:   entrada_pronta = livre[1];
            SEL_C:   entrada_pronta = livre[2];
            default: entrada_pronta = 1'b1;
        endcase
    end

    assign aceita = entrada_valida & entrada_pronta;
    assign carga  = {3{aceita}} & sel_oh;
    assign erro_d = erro_q | (aceita & (sel == SEL_ILEGAL));
    assign erro   = erro_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            erro_q <= 1'b0;
        end else begin
            erro_q <= erro_d;
        end
    end

`ifdef DEMUX_CONT_EN
    demux_slot #(.LARGURA(LARGURA), .CONT_W(CONT_W)) u_slot_a (
        .clock(clock), .reset(reset), .carga(carga[0]), .dado_in(entrada),
        .pronta(saidaA_pronta), .valida(saidaA_valida), .dado_out(saidaA),
        .livre(livre[0]), .cont(contA)
    );
    demux_slot #(.LARGURA(LARGURA), .CONT_W(CONT_W)) u_slot_b (
        .clock(clock), .reset(reset), .carga(carga[1]), .dado_in(entrada),
        .pronta(saidaB_pronta), .valida(saidaB_valida), .dado_out(saidaB),
        .livre(livre[1]), .cont(contB)
    );
    demux_slot #(.LARGURA(LARGURA), .CONT_W(CONT_W)) u_slot_c (
        .clock(clock), .reset(reset), .carga(carga[2]), .dado_in(entrada),
        .pronta(saidaC_pronta), .valida(saidaC_valida), .dado_out(saidaC),
        .livre(livre[2]), .cont(contC)
    );
`else
    demux_slot #(.LARGURA(LARGURA)) u_slot_a (
        .clock(clock), .reset(reset), .carga(carga[0]), .dado_in(entrada),
        .pronta(saidaA_pronta), .valida(saidaA_valida), .dado_out(saidaA),
        .livre(livre[0])
    );
    demux_slot #(.LARGURA(LARGURA)) u_slot_b (
        .clock(clock), .reset(reset), .carga(carga[1]), .dado_in(entrada),
        .pronta(saidaB_pronta), .valida(saidaB_valida), .dado_out(saidaB),
        .livre(livre[1])
    );
    demux_slot #(.LARGURA(LARGURA)) u_slot_c (
        .clock(clock), .reset(reset), .carga(carga[2]), .dado_in(entrada),
        .pronta(saidaC_pronta), .valida(saidaC_valida), .dado_out(saidaC),
        .livre(livre[2])
    );
`endif

endmodule
